overlap_buffer_writer: RTL and testbench



---
 rtl/overlap_pkg.sv | 24 ++
 rtl/segment_occupancy_counter.sv | 46 ++++
 rtl/overlap_buffer_writer.sv | 118 +++++++++++
 tb/tb_overlap_buffer_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/overlap_pkg.sv
// overlap_pkg
//   Memory map shared by the overlap-buffer writer and the overlap/add reader.
//   The 4K-word window memory is split into NUM_SEGS ring segments of
//   WINDOW_SIZE words each; a word address is {segment, word index}.
package overlap_pkg;

  localparam int unsigned WORD_LENGTH      = 16;
  localparam int unsigned HALF_WINDOW_SIZE = 512;
  localparam int unsigned WINDOW_SIZE      = 2 * HALF_WINDOW_SIZE;
  localparam int unsigned WORD_BITS        = $clog2(WINDOW_SIZE);
  localparam int unsigned SEG_BITS         = 2;
  localparam int unsigned NUM_SEGS         = 2 ** SEG_BITS;
  localparam int unsigned SEG_ADDR_BITS    = SEG_BITS + WORD_BITS;

  typedef logic [SEG_BITS-1:0]      seg_t;
  typedef logic [WORD_BITS-1:0]     word_t;
  typedef logic [SEG_ADDR_BITS-1:0] seg_addr_t;

  // Segment-relative word address, before any base offset is applied.
  function automatic seg_addr_t seg_addr(input seg_t seg, input word_t word);
    return {seg, word};
  endfunction

endpackage

// File: rtl/segment_occupancy_counter.sv
// segment_occupancy_counter
//   Counts complete windows held in the ring, 0..2**SEG_BITS.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     inc_i     : a window was committed this cycle
//     dec_i     : the reader freed the oldest segment this cycle
//     count_o   : windows currently held
//     full_o    : every segment holds an unread window
//   An increment is ignored when full and a decrement when empty; when both
//   take effect in the same cycle the count is unchanged.
module segment_occupancy_counter #(
  parameter int unsigned SEG_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [SEG_BITS:0] count_o,
  output logic              full_o
);

  localparam logic [SEG_BITS:0] FULL_CNT = (SEG_BITS + 1)'(2 ** SEG_BITS);

  logic [SEG_BITS:0] count_q, count_d;
  logic              inc_eff, dec_eff;

  always_comb begin
    inc_eff = inc_i && (count_q != FULL_CNT);
    dec_eff = dec_i && (count_q != '0);
    count_d = count_q;
    unique case ({inc_eff, dec_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/overlap_buffer_writer.sv
// overlap_buffer_writer
//   Writes windowed IMDCT samples into the shared window memory, one window
//   per ring segment, and tracks how many complete windows are held.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     in_valid/ready  : sample stream handshake; ready drops when all
//                       segments hold unread windows
//     in_data/in_last : sample and end-of-window marker
//     frame_release   : reader pulse freeing the oldest complete segment
//     mem_we/addr/wdata : registered memory write, one cycle after accept
//     write_seg       : segment currently being filled
//     frames_full     : complete windows held
//     frame_done      : pulse aligned with the write that completes a window
//     err_framing     : pulse aligned with a write whose in_last disagrees
//                       with its position in the window
module overlap_buffer_writer
  import overlap_pkg::*;
#(
  parameter int unsigned             WORD_LENGTH = overlap_pkg::WORD_LENGTH,
  parameter int unsigned             WINDOW_SIZE = overlap_pkg::WINDOW_SIZE,
  parameter int unsigned             SEG_BITS    = overlap_pkg::SEG_BITS,
  parameter int unsigned             ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_BASE   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   frame_release,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic [SEG_BITS-1:0]    write_seg,
  output logic [SEG_BITS:0]      frames_full,
  output logic                   frame_done,
  output logic                   err_framing
);

  localparam int unsigned          IDX_BITS = $clog2(WINDOW_SIZE);
  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(WINDOW_SIZE - 1);

  logic [IDX_BITS-1:0]    word_q, word_d;
  logic [SEG_BITS-1:0]    seg_q, seg_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [WORD_LENGTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic accept, at_end, commit, seg_full;

  segment_occupancy_counter #(
    .SEG_BITS (SEG_BITS)
  ) u_occupancy (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (commit),
    .dec_i   (frame_release),
    .count_o (frames_full),
    .full_o  (seg_full)
  );

  assign in_ready = !seg_full;

  always_comb begin
    accept = in_valid && in_ready;
    at_end = (word_q == LAST_IDX);
    commit = accept && at_end;

    word_d      = word_q;
    seg_d       = seg_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = accept;
    done_d      = commit;
    // A mismatch either way flags an error; only the last index commits.
    err_d       = accept && (in_last != at_end);

    if (accept) begin
      mem_addr_d  = ADDR_BASE + ADDR_WIDTH'(seg_addr(seg_q, word_q));
      mem_wdata_d = in_data;
      // An early in_last abandons the partial window in the same segment.
      if (at_end || in_last) word_d = '0;
      else                   word_d = word_q + 1'b1;
    end
    if (commit) seg_d = seg_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q      <= '0;
      seg_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      word_q      <= word_d;
      seg_q       <= seg_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign write_seg   = seg_q;
  assign frame_done  = done_q;
  assign err_framing = err_q;

endmodule

// File: tb/tb_overlap_buffer_writer.sv
// tb_overlap_buffer_writer
//   Drives the writer from a stimulus task that also advances a window-level
//   reference model (word count, segment, windows held) and queues the write
//   each accepted sample must produce; a separate monitor pops and compares
//   every memory write one cycle after acceptance.
module tb_overlap_buffer_writer;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        frame_release;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  write_seg;
  logic [2:0]  frames_full;
  logic        frame_done;
  logic        err_framing;

  overlap_buffer_writer #(
    .WORD_LENGTH (16),
    .WINDOW_SIZE (1024),
    .SEG_BITS    (2),
    .ADDR_WIDTH  (16),
    .ADDR_BASE   (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .frame_release (frame_release),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .write_seg     (write_seg),
    .frames_full   (frames_full),
    .frame_done    (frame_done),
    .err_framing   (err_framing)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        done;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position inside the current window, segment being
  // filled, and number of complete windows held.
  int m_word = 0;
  int m_seg  = 0;
  int m_full = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted sample must appear as exactly one write on the
  // following edge, carrying its address, data and status pulses.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      me = q.pop_front();
      vectors++;
      if (mem_we !== 1'b1) begin
        miscompares++;
        $display("FAIL write_missing: mem_we=%b required 1 (addr %h)", mem_we, me.addr);
      end else if (mem_addr !== me.addr || mem_wdata !== me.data ||
                   frame_done !== me.done || err_framing !== me.err) begin
        miscompares++;
        $display("FAIL write: addr=%h data=%h done=%b err=%b required addr=%h data=%h done=%b err=%b",
                 mem_addr, mem_wdata, frame_done, err_framing, me.addr, me.data, me.done, me.err);
      end
    end else if (mem_we !== 1'b0 || frame_done !== 1'b0 || err_framing !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle: mem_we=%b done=%b err=%b required 0 0 0", mem_we, frame_done, err_framing);
    end
  end

  // One clock of stimulus, called at a falling edge: check status outputs
  // against the model, apply inputs, advance the model, wait one cycle.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic r, input logic rs);
    bit   m_ready, acc, at_end, rel_eff;
    exp_t e;
    m_ready = (m_full != 4);
    vectors++;
    if (in_ready !== m_ready || frames_full !== 3'(m_full) || write_seg !== 2'(m_seg)) begin
      miscompares++;
      $display("FAIL status: in_ready=%b frames_full=%0d write_seg=%0d required %b %0d %0d",
               in_ready, frames_full, write_seg, m_ready, m_full, m_seg);
    end
    rst           = rs;
    in_valid      = v;
    in_data       = d;
    in_last       = l;
    frame_release = r;
    if (rs) begin
      m_word = 0;
      m_seg  = 0;
      m_full = 0;
      q.delete();
    end else begin
      acc     = v && m_ready;
      at_end  = (m_word == 1023);
      rel_eff = r && (m_full > 0);
      if (acc) begin
        e.addr = BASE + 16'(m_seg * 1024 + m_word);
        e.data = d;
        e.done = at_end;
        e.err  = (l != at_end);
        q.push_back(e);
        if (at_end) begin
          m_word = 0;
          m_seg  = (m_seg + 1) % 4;
        end else if (l) begin
          m_word = 0;
        end else begin
          m_word++;
        end
      end
      m_full = m_full + int'(acc && at_end) - int'(rel_eff);
    end
    @(negedge clk);
  endtask

  task automatic send(input int n, input int last_idx, input int rel_idx, input bit rnd);
    for (int i = 0; i < n; i++)
      step(1'b1, rnd ? 16'($urandom) : 16'(i), i == last_idx, i == rel_idx, 1'b0);
  endtask

  task automatic check_reset();
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 ||
        write_seg !== 2'd0 || frames_full !== 3'd0 || frame_done !== 1'b0 ||
        err_framing !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: we=%b addr=%h wdata=%h seg=%0d full=%0d done=%b err=%b rdy=%b required all 0, rdy 1",
               mem_we, mem_addr, mem_wdata, write_seg, frames_full, frame_done, err_framing, in_ready);
    end
  endtask

  initial begin
    bit v, l, r;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    frame_release = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();

    // First window, data = index.
    send(1024, 1023, -1, 1'b0);
    // Fill the remaining three segments.
    repeat (3) send(1024, 1023, -1, 1'b1);
    // All segments held: valid must not be accepted.
    repeat (3) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    // Fifth window wraps back to segment 0.
    send(1024, 1023, -1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    // Release coincident with the commit while two windows are held.
    send(1024, 1023, 1023, 1'b1);
    // Early in_last at word 500 abandons the partial window.
    send(501, 500, -1, 1'b1);
    // Final word without in_last commits and flags an error.
    send(1024, -1, -1, 1'b1);
    // Drain, plus one release while empty.
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    // Reset part-way through a window with one window held.
    send(1024, 1023, -1, 1'b1);
    send(700, -1, -1, 1'b1);
    step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
    check_reset();
    send(5, -1, -1, 1'b1);

    // Randomised traffic.
    for (int c = 0; c < 20000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      if (m_word == 1023) l = ($urandom_range(0, 9) != 0);
      else                l = ($urandom_range(0, 799) == 0);
      r = ($urandom_range(0, 1199) == 0);
      step(v, 16'($urandom), l, r, 1'b0);
    end

    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d writes outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
